// File: rtl/half_adder.sv
// Registered half adder with WIDTH independent lanes: per lane, sum = a ^ b and
// carry = a & b, presented on flops one cycle after the operands are sampled.
module half_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] carryout
);

    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] carry_d;
    logic [WIDTH-1:0] carry_q;

    // Bitwise operators keep lanes independent; no carry crosses lane boundaries.
    always_comb begin
        s_d     = a ^ b;
        carry_d = a & b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            carry_q <= '0;
        end else begin
            s_q     <= s_d;
            carry_q <= carry_d;
        end
    end

    assign s        = s_q;
    assign carryout = carry_q;

endmodule

// File: tb/tb_half_adder.sv
// Directed scoreboard bench for half_adder: a 1-lane and a 4-lane instance share
// clock and reset; expected sums are queued when driven and checked after the edge.
module tb_half_adder;

    typedef struct packed {
        logic [1:0] e1;
        logic [3:0] es4;
        logic [3:0] ec4;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [0:0] a1, b1, s1, c1;
    logic [3:0] a4, b4, s4, c4;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    half_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .s(s1), .carryout(c1)
    );

    half_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .s(s4), .carryout(c4)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, expv);
        end
    endtask

    // Reference model: arithmetic add per lane, split into {carry, sum}.
    function automatic exp_t model(input logic a1v, input logic b1v,
                                   input logic [3:0] a4v, input logic [3:0] b4v);
        exp_t e;
        logic [1:0] t;
        e.e1 = 2'(a1v) + 2'(b1v);
        for (int i = 0; i < 4; i++) begin
            t = 2'(a4v[i]) + 2'(b4v[i]);
            e.es4[i] = t[0];
            e.ec4[i] = t[1];
        end
        return e;
    endfunction

    task automatic drive(input logic a1v, input logic b1v,
                         input logic [3:0] a4v, input logic [3:0] b4v);
        @(negedge clk);
        a1 = a1v;
        b1 = b1v;
        a4 = a4v;
        b4 = b4v;
        exp_q.push_back(model(a1v, b1v, a4v, b4v));
    endtask

    task automatic collect(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_w1"}, {2'b00, c1, s1}, {2'b00, e.e1});
            check({tag, "_s4"}, s4, e.es4);
            check({tag, "_c4"}, c4, e.ec4);
        end
    endtask

    task automatic step(input string tag, input logic a1v, input logic b1v,
                        input logic [3:0] a4v, input logic [3:0] b4v);
        drive(a1v, b1v, a4v, b4v);
        collect(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a1 = 1'b1;
        b1 = 1'b1;
        a4 = 4'hF;
        b4 = 4'hF;

        // Reset held with all-ones inputs while the clock runs.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold_w1", {2'b00, c1, s1}, 4'b0000);
            check("rst_hold_s4", s4, 4'b0000);
            check("rst_hold_c4", c4, 4'b0000);
        end

        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive single-lane sequence, with varied 4-lane patterns alongside.
        step("seq00", 1'b0, 1'b0, 4'b0000, 4'b0000);
        step("seq01", 1'b0, 1'b1, 4'b0101, 4'b0011);
        step("seq10", 1'b1, 1'b0, 4'b1111, 4'b0000);
        step("seq01b", 1'b0, 1'b1, 4'b1111, 4'b1111);
        step("seq11", 1'b1, 1'b1, 4'b1100, 4'b1010);

        // Latency: outputs must not follow a mid-cycle input change.
        step("lat_pre", 1'b0, 1'b0, 4'b0000, 4'b0000);
        drive(1'b1, 1'b1, 4'b1100, 4'b1010);
        #5;
        check("lat_hold_w1", {2'b00, c1, s1}, 4'b0000);
        check("lat_hold_s4", s4, 4'b0000);
        check("lat_hold_c4", c4, 4'b0000);
        collect("lat_post");

        // Asynchronous reset between edges while carry is 1.
        #4;
        rst_n = 1'b0;
        #1;
        check("async_rst_w1", {2'b00, c1, s1}, 4'b0000);
        check("async_rst_s4", s4, 4'b0000);
        check("async_rst_c4", c4, 4'b0000);
        @(posedge clk);
        #1;
        check("rst_edge_w1", {2'b00, c1, s1}, 4'b0000);
        check("rst_edge_c4", c4, 4'b0000);

        // Recovery: release reset with a=1, b=0.
        @(negedge clk);
        a1 = 1'b1;
        b1 = 1'b0;
        a4 = 4'b1001;
        b4 = 4'b0011;
        rst_n = 1'b1;
        exp_q.push_back(model(1'b1, 1'b0, 4'b1001, 4'b0011));
        collect("recover");

        // Back-to-back results at full throughput.
        drive(1'b1, 1'b1, 4'b0110, 4'b0110);
        collect("b2b_a");
        drive(1'b0, 1'b1, 4'b1000, 4'b0001);
        collect("b2b_b");

        check("queue_drained", 4'(exp_q.size()), 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
